// File: rtl/decode_pkg.sv
// decode_pkg: RV32I opcode/funct3 constants, the decoded-control bundle
// (ctrl_t) captured by the ID/EX register, and the shared arithmetic
// funct3/funct7 -> ALU operation map used by R-type and I-type ALU ops.
`include "def.sv"

package decode_pkg;

    localparam logic [6:0] OPC_OP     = `OPC_OP;
    localparam logic [6:0] OPC_OP_IMM = `OPC_OP_IMM;
    localparam logic [6:0] OPC_LUI    = `OPC_LUI;
    localparam logic [6:0] OPC_AUIPC  = `OPC_AUIPC;
    localparam logic [6:0] OPC_LOAD   = `OPC_LOAD;
    localparam logic [6:0] OPC_STORE  = `OPC_STORE;
    localparam logic [6:0] OPC_BRANCH = `OPC_BRANCH;
    localparam logic [6:0] OPC_JAL    = `OPC_JAL;
    localparam logic [6:0] OPC_JALR   = `OPC_JALR;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;

    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;

    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_SH   = 3'b001;
    localparam logic [2:0] F3_SW   = 3'b010;

    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [3:0]  alu_ctrl;
        logic        src_a_pc;
        logic        src_b_imm;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        branch_inv;
        logic        illegal;
    } ctrl_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] alu;
    } arith_t;

    // For immediates funct7 is part of the immediate, so it only matters
    // for the shift-immediates; SUB has no immediate form.
    function automatic arith_t arith_map(input logic [2:0] funct3,
                                         input logic [6:0] funct7,
                                         input logic       is_reg);
        arith_t r;
        r.legal = 1'b0;
        r.alu   = `ALU_OPCODE_ADD;
        case (funct3)
            F3_ADD: begin
                if (!is_reg || funct7 == F7_BASE) begin
                    r.legal = 1'b1;
                    r.alu   = `ALU_OPCODE_ADD;
                end else if (funct7 == F7_ALT) begin
                    r.legal = 1'b1;
                    r.alu   = `ALU_OPCODE_SUB;
                end
            end
            F3_SLL: begin
                r.legal = (funct7 == F7_BASE);
                r.alu   = `ALU_OPCODE_LSL;
            end
            F3_SLT: begin
                r.legal = !is_reg || funct7 == F7_BASE;
                r.alu   = `ALU_OPCODE_SLT;
            end
            F3_XOR: begin
                r.legal = !is_reg || funct7 == F7_BASE;
                r.alu   = `ALU_OPCODE_XOR;
            end
            F3_SR: begin
                if (funct7 == F7_BASE) begin
                    r.legal = 1'b1;
                    r.alu   = `ALU_OPCODE_LSR;
                end else if (funct7 == F7_ALT) begin
                    r.legal = 1'b1;
                    r.alu   = `ALU_OPCODE_ASR;
                end
            end
            F3_OR: begin
                r.legal = !is_reg || funct7 == F7_BASE;
                r.alu   = `ALU_OPCODE_OR;
            end
            F3_AND: begin
                r.legal = !is_reg || funct7 == F7_BASE;
                r.alu   = `ALU_OPCODE_AND;
            end
            default: r.legal = 1'b0;    // SLTU / SLTIU not supported
        endcase
        return r;
    endfunction

endpackage

// File: rtl/decode_stage_alu_ctrl_decoder.sv
// alu_ctrl_decoder: purely combinational RV32I instruction -> ctrl_t.
// Ports:
//   instr_i  32-bit instruction word
//   ctrl_o   decoded ALU control, immediate, register indices and flags
// Unsupported encodings produce illegal=1 with every side-effect flag
// cleared and ALU op forced to ADD; register indices stay as raw fields.
`include "def.sv"

module alu_ctrl_decoder
    import decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                    instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'h000};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                    instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        ctrl_t  c;
        arith_t am;
        logic   legal;

        c          = '0;
        c.rd       = instr_i[11:7];
        c.rs1      = instr_i[19:15];
        c.rs2      = instr_i[24:20];
        c.alu_ctrl = `ALU_OPCODE_ADD;
        am         = '0;
        legal      = 1'b1;

        case (opcode)
            OPC_OP: begin
                am          = arith_map(funct3, funct7, 1'b1);
                legal       = am.legal;
                c.alu_ctrl  = am.alu;
                c.reg_write = 1'b1;
            end
            OPC_OP_IMM: begin
                am          = arith_map(funct3, funct7, 1'b0);
                legal       = am.legal;
                c.alu_ctrl  = am.alu;
                c.src_b_imm = 1'b1;
                c.imm       = imm_i;
                c.reg_write = 1'b1;
            end
            OPC_LUI: begin
                c.alu_ctrl  = `ALU_OPCODE_B;
                c.src_b_imm = 1'b1;
                c.imm       = imm_u;
                c.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                c.src_a_pc  = 1'b1;
                c.src_b_imm = 1'b1;
                c.imm       = imm_u;
                c.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                legal       = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
                c.src_b_imm = 1'b1;
                c.imm       = imm_i;
                c.mem_read  = 1'b1;
                c.reg_write = 1'b1;
            end
            OPC_STORE: begin
                legal       = funct3 inside {F3_SB, F3_SH, F3_SW};
                c.src_b_imm = 1'b1;
                c.imm       = imm_s;
                c.mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                // EQ of SUB is the equality test; EQ of SLT is "not less than".
                c.branch = 1'b1;
                c.imm    = imm_b;
                case (funct3)
                    F3_BEQ: begin c.alu_ctrl = `ALU_OPCODE_SUB; c.branch_inv = 1'b0; end
                    F3_BNE: begin c.alu_ctrl = `ALU_OPCODE_SUB; c.branch_inv = 1'b1; end
                    F3_BLT: begin c.alu_ctrl = `ALU_OPCODE_SLT; c.branch_inv = 1'b1; end
                    F3_BGE: begin c.alu_ctrl = `ALU_OPCODE_SLT; c.branch_inv = 1'b0; end
                    default: legal = 1'b0;  // BLTU / BGEU and reserved
                endcase
            end
            OPC_JAL: begin
                c.src_a_pc  = 1'b1;
                c.src_b_imm = 1'b1;
                c.imm       = imm_j;
                c.jump      = 1'b1;
                c.reg_write = 1'b1;
            end
            OPC_JALR: begin
                legal       = (funct3 == F3_JALR);
                c.src_b_imm = 1'b1;
                c.imm       = imm_i;
                c.jump      = 1'b1;
                c.reg_write = 1'b1;
            end
            default: legal = 1'b0;      // FENCE, SYSTEM, unknown opcodes
        endcase

        if (!legal) begin
            c.alu_ctrl   = `ALU_OPCODE_ADD;
            c.src_a_pc   = 1'b0;
            c.src_b_imm  = 1'b0;
            c.imm        = '0;
            c.reg_write  = 1'b0;
            c.mem_read   = 1'b0;
            c.mem_write  = 1'b0;
            c.jump       = 1'b0;
            c.branch     = 1'b0;
            c.branch_inv = 1'b0;
            c.illegal    = 1'b1;
        end

        ctrl_o = c;
    end

endmodule

// File: rtl/def.sv
// Shared RV32I opcode constants and ALU operation codes.
// The ALU in EX decodes ALUctrl using exactly these values.
`ifndef DEF_SV
`define DEF_SV

`define OPC_OP      7'b0110011
`define OPC_OP_IMM  7'b0010011
`define OPC_LUI     7'b0110111
`define OPC_AUIPC   7'b0010111
`define OPC_LOAD    7'b0000011
`define OPC_STORE   7'b0100011
`define OPC_BRANCH  7'b1100011
`define OPC_JAL     7'b1101111
`define OPC_JALR    7'b1100111

`define ALU_OPCODE_ADD  4'd0
`define ALU_OPCODE_SUB  4'd1
`define ALU_OPCODE_AND  4'd2
`define ALU_OPCODE_OR   4'd3
`define ALU_OPCODE_XOR  4'd4
`define ALU_OPCODE_LSL  4'd5
`define ALU_OPCODE_LSR  4'd6
`define ALU_OPCODE_ASR  4'd7
`define ALU_OPCODE_SLT  4'd8
`define ALU_OPCODE_B    4'd9

`endif

// File: rtl/decode_stage.sv
// decode_stage: RV32I ID stage. Decodes the fetched instruction and holds
// the result in a single-entry ID/EX register with valid/ready handshake.
// Ports:
//   clk, rst (sync, active-high), flush (drop held + incoming instruction)
//   in_valid/in_ready, instr, pc_in           fetch side
//   out_valid/out_ready, pc_out               execute side
//   ALUctrl, src_a_pc, src_b_imm, imm, rd, rs1, rs2,
//   reg_write, mem_read, mem_write, jump, branch, branch_inv, illegal
// Only WIDTH = 32 is supported; the decoded bundle is fixed at 32 bits.
module decode_stage
    import decode_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] instr,
    input  logic [WIDTH-1:0] pc_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] pc_out,
    output logic [3:0]       ALUctrl,
    output logic             src_a_pc,
    output logic             src_b_imm,
    output logic [WIDTH-1:0] imm,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             jump,
    output logic             branch,
    output logic             branch_inv,
    output logic             illegal
);

    ctrl_t            dec_ctrl;
    ctrl_t            ctrl_d, ctrl_q;
    logic             valid_d, valid_q;
    logic [WIDTH-1:0] pc_d, pc_q;

    alu_ctrl_decoder u_dec (
        .instr_i (instr),
        .ctrl_o  (dec_ctrl)
    );

    assign in_ready = !valid_q || out_ready;

    // Flush only clears valid; the held fields stay bit-stable.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                ctrl_d = dec_ctrl;
                pc_d   = pc_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid  = valid_q;
    assign pc_out     = pc_q;
    assign ALUctrl    = ctrl_q.alu_ctrl;
    assign src_a_pc   = ctrl_q.src_a_pc;
    assign src_b_imm  = ctrl_q.src_b_imm;
    assign imm        = ctrl_q.imm;
    assign rd         = ctrl_q.rd;
    assign rs1        = ctrl_q.rs1;
    assign rs2        = ctrl_q.rs2;
    assign reg_write  = ctrl_q.reg_write;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign jump       = ctrl_q.jump;
    assign branch     = ctrl_q.branch;
    assign branch_inv = ctrl_q.branch_inv;
    assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage. Random instructions are built by an
// encoder from a mnemonic table, so the expected decode is known from the
// mnemonic rather than recomputed from the bits. A one-entry model tracks
// the ID/EX register under reset/flush/stall.
module tb_decode_stage;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR  = 4'd3,
                           A_XOR = 4'd4, A_LSL = 4'd5, A_LSR = 4'd6, A_ASR = 4'd7,
                           A_SLT = 4'd8, A_B   = 4'd9;

    localparam logic [31:0] I_ADD  = 32'h002081B3, I_SUB  = 32'h402081B3,
                            I_ADDI = 32'hFFF00093, I_BNE  = 32'h00209463,
                            I_LUI  = 32'h123452B7, I_SLTU = 32'h0020B1B3,
                            I_BAD  = 32'h0000007F;

    typedef struct packed {
        logic [3:0]  alu;
        logic        a_pc, b_imm;
        logic [31:0] imm;
        logic [4:0]  rd, rs1, rs2;
        logic        rw, mr, mw, j, br, bi, ill;
        logic        chk_imm, chk_src;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] instr = '0, pc_in = '0;
    logic        in_ready, out_valid;
    logic [31:0] pc_out, imm;
    logic [3:0]  ALUctrl;
    logic        src_a_pc, src_b_imm;
    logic [4:0]  rd, rs1, rs2;
    logic        reg_write, mem_read, mem_write, jump, branch, branch_inv, illegal;

    int   n_checks = 0;
    int   n_fail   = 0;

    bit          m_valid = 1'b0;
    bit          m_known = 1'b0;
    exp_t        m = '0;
    logic [31:0] m_pc = '0;

    decode_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc_in(pc_in), .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .ALUctrl(ALUctrl), .src_a_pc(src_a_pc), .src_b_imm(src_b_imm),
        .imm(imm), .rd(rd), .rs1(rs1), .rs2(rs2), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .jump(jump), .branch(branch),
        .branch_inv(branch_inv), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // flags = {a_pc, b_imm, rw, mr, mw, j, br, bi}
    function automatic exp_t mk(input logic [3:0] alu, input logic [7:0] flags,
                                input logic [31:0] iv, input logic [31:0] ins);
        exp_t e;
        e = '0;
        e.alu = alu;
        {e.a_pc, e.b_imm, e.rw, e.mr, e.mw, e.j, e.br, e.bi} = flags;
        e.imm = iv;
        e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
        e.chk_imm = 1'b1; e.chk_src = 1'b1;
        return e;
    endfunction

    function automatic exp_t mk_ill(input logic [31:0] ins);
        exp_t e;
        e = mk(A_ADD, 8'b0000_0000, 32'h0, ins);
        e.ill = 1'b1; e.chk_imm = 1'b0; e.chk_src = 1'b0;
        return e;
    endfunction

    function automatic void gen(input int k, output logic [31:0] ins, output exp_t e);
        logic [4:0]  rdv, rs1v, rs2v;
        logic [31:0] r;
        logic [2:0]  f3;
        logic [6:0]  f7, op;
        logic [3:0]  alu;
        logic [11:0] i12;
        logic [12:0] b;
        logic [20:0] jj;
        logic [31:0] si;
        bit          ill;
        rdv = 5'($urandom); rs1v = 5'($urandom); rs2v = 5'($urandom);
        r = $urandom; f3 = 3'd0; f7 = 7'd0; alu = A_ADD; ill = 1'b0;
        i12 = r[11:0];
        si = {{20{i12[11]}}, i12};
        ins = '0;
        e = '0;
        case (k)
            0:  begin f3 = 3'd0; alu = A_ADD; end
            1:  begin f3 = 3'd0; f7 = 7'h20; alu = A_SUB; end
            2:  begin f3 = 3'd1; alu = A_LSL; end
            3:  begin f3 = 3'd2; alu = A_SLT; end
            4:  begin f3 = 3'd4; alu = A_XOR; end
            5:  begin f3 = 3'd5; alu = A_LSR; end
            6:  begin f3 = 3'd5; f7 = 7'h20; alu = A_ASR; end
            7:  begin f3 = 3'd6; alu = A_OR; end
            8:  begin f3 = 3'd7; alu = A_AND; end
            9:  begin f3 = 3'd0; alu = A_ADD; end
            10: begin f3 = 3'd2; alu = A_SLT; end
            11: begin f3 = 3'd4; alu = A_XOR; end
            12: begin f3 = 3'd6; alu = A_OR; end
            13: begin f3 = 3'd7; alu = A_AND; end
            14: begin f3 = 3'd1; alu = A_LSL; end
            15: begin f3 = 3'd5; alu = A_LSR; end
            16: begin f3 = 3'd5; f7 = 7'h20; alu = A_ASR; end
            default: ;
        endcase
        if (k <= 8) begin
            ins = {f7, rs2v, rs1v, f3, rdv, 7'h33};
            e = mk(alu, 8'b0010_0000, 32'h0, ins);
            e.chk_imm = 1'b0;
        end else if (k <= 16) begin
            if (k >= 14) i12 = {f7, rs2v};
            si = {{20{i12[11]}}, i12};
            ins = {i12, rs1v, f3, rdv, 7'h13};
            e = mk(alu, 8'b0110_0000, si, ins);
        end else begin
            case (k)
                17: begin ins = {r[31:12], rdv, 7'h37};
                          e = mk(A_B, 8'b0110_0000, {r[31:12], 12'h0}, ins); end
                18: begin ins = {r[31:12], rdv, 7'h17};
                          e = mk(A_ADD, 8'b1110_0000, {r[31:12], 12'h0}, ins); end
                19: begin
                    case ($urandom_range(0, 4))
                        0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
                    endcase
                    ins = {i12, rs1v, f3, rdv, 7'h03};
                    e = mk(A_ADD, 8'b0111_0000, si, ins);
                end
                20: begin
                    f3 = 3'($urandom_range(0, 2));
                    ins = {i12[11:5], rs2v, rs1v, f3, i12[4:0], 7'h23};
                    e = mk(A_ADD, 8'b0100_1000, si, ins);
                end
                21, 22, 23, 24: begin
                    b = r[12:0]; b[0] = 1'b0;
                    f3 = (k == 21) ? 3'd0 : (k == 22) ? 3'd1 : (k == 23) ? 3'd4 : 3'd5;
                    ins = {b[12], b[10:5], rs2v, rs1v, f3, b[4:1], b[11], 7'h63};
                    e = mk((k <= 22) ? A_SUB : A_SLT,
                           (k == 22 || k == 23) ? 8'b0000_0011 : 8'b0000_0010,
                           {{19{b[12]}}, b}, ins);
                end
                25: begin
                    jj = r[20:0]; jj[0] = 1'b0;
                    ins = {jj[20], jj[10:1], jj[11], jj[19:12], rdv, 7'h6f};
                    e = mk(A_ADD, 8'b1110_0100, {{11{jj[20]}}, jj}, ins);
                end
                26: begin ins = {i12, rs1v, 3'b000, rdv, 7'h67};
                          e = mk(A_ADD, 8'b0110_0100, si, ins); end
                27: begin ins = {7'h00, rs2v, rs1v, 3'd3, rdv, 7'h33}; ill = 1'b1; end
                28: begin ins = {i12, rs1v, 3'd3, rdv, 7'h13}; ill = 1'b1; end
                29: begin
                    f3 = 3'($urandom_range(2, 3) + 4 * $urandom_range(0, 1));
                    ins = {r[31:25], rs2v, rs1v, f3, r[11:7], 7'h63}; ill = 1'b1;
                end
                30: begin ins = {r[31:7], ($urandom_range(0, 1) != 0) ? 7'h0f : 7'h73}; ill = 1'b1; end
                31: begin
                    do op = 7'($urandom);
                    while (op inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23,
                                      7'h63, 7'h6f, 7'h67, 7'h0f, 7'h73});
                    ins = {r[31:7], op}; ill = 1'b1;
                end
                32: begin
                    f3 = 3'($urandom);
                    do f7 = 7'($urandom);
                    while (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
                    ins = {f7, rs2v, rs1v, f3, rdv, 7'h33}; ill = 1'b1;
                end
                33: begin
                    f3 = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5;
                    do f7 = 7'($urandom);
                    while (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5));
                    ins = {f7, rs2v, rs1v, f3, rdv, 7'h13}; ill = 1'b1;
                end
                34: begin
                    case ($urandom_range(0, 2))
                        0: f3 = 3'd3; 1: f3 = 3'd6; default: f3 = 3'd7;
                    endcase
                    ins = {i12, rs1v, f3, rdv, 7'h03}; ill = 1'b1;
                end
                35: begin
                    f3 = 3'($urandom_range(3, 7));
                    ins = {i12[11:5], rs2v, rs1v, f3, i12[4:0], 7'h23}; ill = 1'b1;
                end
                default: begin
                    f3 = 3'($urandom_range(1, 7));
                    ins = {i12, rs1v, f3, rdv, 7'h67}; ill = 1'b1;
                end
            endcase
            if (ill) e = mk_ill(ins);
        end
    endfunction

    task automatic check_outputs();
        check_eq("out_valid",  32'(out_valid),  32'(m_valid));
        check_eq("pc_out",     pc_out,          m_pc);
        check_eq("ALUctrl",    32'(ALUctrl),    32'(m.alu));
        check_eq("rd",         32'(rd),         32'(m.rd));
        check_eq("rs1",        32'(rs1),        32'(m.rs1));
        check_eq("rs2",        32'(rs2),        32'(m.rs2));
        check_eq("reg_write",  32'(reg_write),  32'(m.rw));
        check_eq("mem_read",   32'(mem_read),   32'(m.mr));
        check_eq("mem_write",  32'(mem_write),  32'(m.mw));
        check_eq("jump",       32'(jump),       32'(m.j));
        check_eq("branch",     32'(branch),     32'(m.br));
        check_eq("branch_inv", 32'(branch_inv), 32'(m.bi));
        check_eq("illegal",    32'(illegal),    32'(m.ill));
        if (m.chk_src) begin
            check_eq("src_a_pc",  32'(src_a_pc),  32'(m.a_pc));
            check_eq("src_b_imm", 32'(src_b_imm), 32'(m.b_imm));
        end
        if (m.chk_imm) check_eq("imm", imm, m.imm);
    endtask

    // One clock: drive at negedge, check in_ready, step model at posedge,
    // check registered outputs at the following negedge.
    task automatic cyc(input bit r, input bit fl, input bit iv, input bit ordy,
                       input logic [31:0] ins, input logic [31:0] pcv, input exp_t e);
        rst = r; flush = fl; in_valid = iv; out_ready = ordy; instr = ins; pc_in = pcv;
        #1;
        if (m_known && !r) check_eq("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0; m = '0; m.chk_imm = 1'b1; m.chk_src = 1'b1;
            m_pc = '0; m_known = 1'b1;
        end else if (fl) begin
            m_valid = 1'b0;
        end else if (!m_valid || ordy) begin
            m_valid = iv;
            if (iv) begin m = e; m_pc = pcv; end
        end
        @(negedge clk);
        if (m_known) check_outputs();
    endtask

    initial begin
        exp_t        e_add, e_sub, e_addi, e_bne, e_lui, e_sltu, e_bad, e;
        logic [31:0] ins;

        e_add  = mk(A_ADD, 8'b0010_0000, 32'h0, I_ADD);  e_add.chk_imm = 1'b0;
        e_sub  = mk(A_SUB, 8'b0010_0000, 32'h0, I_SUB);  e_sub.chk_imm = 1'b0;
        e_addi = mk(A_ADD, 8'b0110_0000, 32'hFFFFFFFF, I_ADDI);
        e_bne  = mk(A_SUB, 8'b0000_0011, 32'h00000008, I_BNE);
        e_lui  = mk(A_B,   8'b0110_0000, 32'h12345000, I_LUI);
        e_sltu = mk_ill(I_SLTU);
        e_bad  = mk_ill(I_BAD);

        cyc(1'b1, 1'b0, 1'b1, 1'b1, I_ADD, 32'h100, e_add);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, I_ADD, 32'h100, e_add);
        check_eq("reset_out_valid", 32'(out_valid), 32'h0);
        check_eq("reset_in_ready",  32'(in_ready),  32'h1);

        cyc(1'b0, 1'b0, 1'b1, 1'b1, I_ADD, 32'h0000_1000, e_add);
        check_eq("add_valid", 32'(out_valid), 32'h1);
        check_eq("add_alu",   32'(ALUctrl),   32'(A_ADD));
        check_eq("add_rd",    32'(rd),        32'd3);
        check_eq("add_rs1",   32'(rs1),       32'd1);
        check_eq("add_rs2",   32'(rs2),       32'd2);
        check_eq("add_rw",    32'(reg_write), 32'h1);
        check_eq("add_bimm",  32'(src_b_imm), 32'h0);
        check_eq("add_ill",   32'(illegal),   32'h0);

        cyc(1'b0, 1'b0, 1'b1, 1'b1, I_SUB, 32'h0000_1004, e_sub);
        check_eq("sub_alu", 32'(ALUctrl), 32'(A_SUB));
        cyc(1'b0, 1'b0, 1'b1, 1'b1, I_ADDI, 32'h0000_1008, e_addi);
        check_eq("addi_imm",  imm, 32'hFFFFFFFF);
        check_eq("addi_bimm", 32'(src_b_imm), 32'h1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, I_BNE, 32'h0000_100C, e_bne);
        check_eq("bne_alu", 32'(ALUctrl),    32'(A_SUB));
        check_eq("bne_br",  32'(branch),     32'h1);
        check_eq("bne_inv", 32'(branch_inv), 32'h1);
        check_eq("bne_imm", imm,             32'h8);
        check_eq("bne_rw",  32'(reg_write),  32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, I_LUI, 32'h0000_1010, e_lui);
        check_eq("lui_alu", 32'(ALUctrl), 32'(A_B));
        check_eq("lui_imm", imm,          32'h12345000);
        check_eq("lui_rd",  32'(rd),      32'd5);

        cyc(1'b0, 1'b0, 1'b1, 1'b1, I_ADD, 32'h0000_2000, e_add);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, I_SUB, 32'h0000_2004, e_sub);
            check_eq("stall_in_ready", 32'(in_ready), 32'h0);
            check_eq("stall_alu",      32'(ALUctrl),  32'(A_ADD));
            check_eq("stall_pc",       pc_out,        32'h0000_2000);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b1, I_SUB, 32'h0000_2004, e_sub);
        check_eq("unstall_alu", 32'(ALUctrl), 32'(A_SUB));
        check_eq("unstall_pc",  pc_out,       32'h0000_2004);

        cyc(1'b0, 1'b1, 1'b1, 1'b1, I_ADD, 32'h0000_3000, e_add);
        check_eq("flush_valid", 32'(out_valid), 32'h0);

        cyc(1'b0, 1'b0, 1'b1, 1'b1, I_LUI, 32'h0000_4000, e_lui);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, I_ADD, 32'h0000_4004, e_add);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, I_ADD, 32'h0000_4004, e_add);
        check_eq("rst_stall_valid", 32'(out_valid), 32'h0);
        check_eq("rst_stall_alu",   32'(ALUctrl),   32'h0);
        check_eq("rst_stall_imm",   imm,            32'h0);
        check_eq("rst_stall_rd",    32'(rd),        32'h0);
        check_eq("rst_stall_pc",    pc_out,         32'h0);

        cyc(1'b0, 1'b0, 1'b1, 1'b1, I_SLTU, 32'h0000_5000, e_sltu);
        check_eq("sltu_ill", 32'(illegal),   32'h1);
        check_eq("sltu_rw",  32'(reg_write), 32'h0);
        check_eq("sltu_alu", 32'(ALUctrl),   32'(A_ADD));
        cyc(1'b0, 1'b0, 1'b1, 1'b1, I_BAD, 32'h0000_5004, e_bad);
        check_eq("op7f_ill",   32'(illegal),   32'h1);
        check_eq("op7f_rw",    32'(reg_write), 32'h0);
        check_eq("op7f_mw",    32'(mem_write), 32'h0);
        check_eq("op7f_br",    32'(branch),    32'h0);
        check_eq("op7f_jump",  32'(jump),      32'h0);
        check_eq("op7f_alu",   32'(ALUctrl),   32'(A_ADD));
        check_eq("op7f_valid", 32'(out_valid), 32'h1);

        for (int i = 0; i < 3000; i++) begin
            gen(int'($urandom_range(0, 36)), ins, e);
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                ins, $urandom, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID-stage control producer for the execute-stage ALU. It decodes a fetched RV32I instruction into the 4-bit ALU control code, immediate, register indices and control flags.
- Results are registered into a single-entry ID/EX pipeline register with valid/ready handshake, stall and flush.
- Branch flags tell the EX stage how to consume the ALU's EQ output.

Parameters:
- WIDTH, 32, datapath/instruction/PC width; only 32 supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard the current and incoming instruction (branch taken in EX)
- in_valid  in  1  fetch presents instr/pc
- in_ready  out  1  stage can accept this cycle
- instr  in  WIDTH  instruction word
- pc_in  in  WIDTH  instruction address
- out_valid  out  1  ID/EX register holds a decoded instruction
- out_ready  in  1  EX accepts this cycle
- pc_out  out  WIDTH  registered pc_in
- ALUctrl  out  4  ALU operation, values from the `ALU_OPCODE_* macros in def.sv
- src_a_pc  out  1  ALU a = PC (else rs1 data)
- src_b_imm  out  1  ALU b = imm (else rs2 data)
- imm  out  WIDTH  sign-extended immediate
- rd, rs1, rs2  out  5 each  register indices
- reg_write, mem_read, mem_write, jump  out  1 each  control flags
- branch  out  1  conditional branch
- branch_inv  out  1  branch taken when EQ==0 (else when EQ==1)
- illegal  out  1  unsupported or undecodable instruction

Behaviour:
- Handshake: in_ready = !out_valid || out_ready (combinational).
- Transfer occurs when in_valid && in_ready. Latency is 1 cycle: decoded fields are visible the cycle after transfer.
- Reset (synchronous): out_valid=0 and every registered output=0.
- Priority at each clk edge is rst > flush > load.
  - flush: out_valid<=0 and other fields are held; an in_valid in the same cycle is dropped.
  - load: when in_ready, out_valid<=in_valid; fields load only when in_valid=1.
- Stall: while out_valid && !out_ready, all outputs hold bit-stable and in_ready=0.
- Immediates follow RV32I I/S/B/U/J formats, all sign-extended. B and J immediates have bit 0 = 0.
- Decode map (ALUctrl / flags):
  - R-type: ADD/SUB by funct7[5]; AND, OR, XOR, SLL→LSL, SRL→LSR, SRA→ASR, SLT. reg_write=1.
  - I-type ALU: same map with src_b_imm=1. SUB is not encoded. srai is selected by funct7=0100000; shift-immediates with any other funct7 are illegal.
  - LUI: ALU_OPCODE_B, src_b_imm=1.
  - AUIPC: ADD, src_a_pc=1, src_b_imm=1.
  - LOAD (LW/LH/LB/LHU/LBU): ADD, src_b_imm=1, mem_read=1, reg_write=1.
  - STORE: ADD, src_b_imm=1, mem_write=1.
  - BEQ: SUB, branch=1, branch_inv=0. BNE: SUB, branch=1, branch_inv=1.
  - BLT: SLT, branch=1, branch_inv=1. BGE: SLT, branch=1, branch_inv=0.
  - JAL: ADD, src_a_pc=1, src_b_imm=1, jump=1, reg_write=1.
  - JALR: ADD, src_b_imm=1, jump=1, reg_write=1.
- Unsupported cases, all illegal=1: SLTU/SLTIU, BLTU/BGEU, FENCE/SYSTEM, unknown opcode, and bad funct7.
  - When illegal=1: reg_write, mem_read, mem_write, branch and jump are all 0; ALUctrl=ADD; out_valid still follows the handshake.
- rd is reported as decoded. rd=0 writes are not suppressed here.

Decomposition:
- Opcode constants and the `ALU_OPCODE_* macros remain in def.sv.
- New package decode_pkg holds:
  - RV32I opcode/funct3 localparams;
  - ctrl_t packed struct bundling all decoded fields, so one register captures it.
- Sub-module alu_ctrl_decoder: purely combinational instr → ctrl_t. decode_stage owns the handshake and the register.

Test Plan:
- add x3,x1,x2 (0x002081B3), in_valid=1, out_ready=1 → next cycle: out_valid=1, ALUctrl=ADD, rd=3, rs1=1, rs2=2, reg_write=1, src_b_imm=0, illegal=0.
- sub (0x402081B3) → ALUctrl=SUB. addi x1,x0,-1 (0xFFF00093) → ADD, src_b_imm=1, imm=0xFFFFFFFF.
- bne x1,x2,+8 (0x00209463) → SUB, branch=1, branch_inv=1, imm=0x00000008, reg_write=0. lui x5,0x12345 (0x123452B7) → ALU_OPCODE_B, imm=0x12345000, rd=5.
- Load add, then hold out_ready=0 for 3 cycles with a new instr presented → in_ready=0 and outputs unchanged throughout. Raise out_ready → new instr appears 1 cycle later.
- flush=1 together with in_valid=1 → out_valid=0 next cycle. rst mid-stall → out_valid=0 and all outputs 0 after the edge.
- sltu (0x0020B1B3) and opcode 0x7F → illegal=1, reg_write=mem_write=branch=jump=0, ALUctrl=ADD.
